speicher_arbiter: RTL and testbench
===================================

// Module: speicher_arbiter
// PURPOSE
// Parametrised memory arbiter that lets KANAELE requesters (CPU instruction fetch, CPU data port,
// further CPUs or DMA) share one memory port. Each channel uses the CPU's level-request /
// done-pulse handshake, so CPU ports connect directly. Adds round-robin or fixed priority, a
// configurable address/data width and a response timeout that a single-CPU bus does not have.
// PARAMETERS
// KANAELE        2   number of requester channels (1..8)
// ADRESSBREITE   32  address width
// DATENBREITE    32  data width
// FESTE_PRIO     0   0 = round-robin arbitration, 1 = fixed priority (lowest index wins)
// ZEITLIMIT      255 max cycles waiting for MemBereit; 0 disables the timeout
// PORTS
// Clock          in   1                       system clock, all state on rising edge
// Reset          in   1                       asynchronous, active-high reset
// Lesen          in   KANAELE                 per-channel read request, level, held until done
// Schreiben      in   KANAELE                 per-channel write request, level, held until done
// Adresse        in   KANAELE*ADRESSBREITE    per-channel address, channel k at [k*AB +: AB]
// DatenRaus      in   KANAELE*DATENBREITE     per-channel write data, channel k at [k*DB +: DB]
// DatenRein      out  DATENBREITE             read data, shared, valid in the Geladen cycle
// Geladen        out  KANAELE                 one-cycle read-done pulse for channel k
// Gespeichert    out  KANAELE                 one-cycle write-done pulse for channel k
// Fehler         out  KANAELE                 one-cycle timeout pulse, coincides with done pulse
// MemAdresse     out  ADRESSBREITE            memory address
// MemSchreibDaten out DATENBREITE             memory write data
// MemLesen       out  1                       memory read strobe, level, held until MemBereit
// MemSchreiben   out  1                       memory write strobe, level, held until MemBereit
// MemLeseDaten   in   DATENBREITE             memory read data, sampled when MemBereit=1
// MemBereit      in   1                       memory access complete, one cycle
// BEHAVIOUR
// - Reset (async): state LEERLAUF, RR pointer 0, all outputs 0; access in flight abandoned, no pulse.
// - States: LEERLAUF -> ZUGRIFF -> ANTWORT -> LEERLAUF.
// - LEERLAUF: channel k requests if Lesen[k]|Schreiben[k]. Winner chosen combinationally; at the
//   edge latch index, kind, Adresse, DatenRaus; go to ZUGRIFF. No request: stay.
// - Arbitration: FESTE_PRIO=1 lowest requesting index. FESTE_PRIO=0 first requesting index at or
//   above RR pointer, wrapping modulo KANAELE; pointer <= winner+1 (wrap) at grant.
// - Lesen and Schreiben both high on one channel: write served, read ignored for that grant.
// - ZUGRIFF: MemAdresse/MemSchreibDaten driven from latches; MemLesen or MemSchreiben high.
//   On MemBereit=1: latch MemLeseDaten (reads) into DatenRein, go to ANTWORT. Min latency:
//   request seen cycle t, strobe from t+1, MemBereit at t+1 -> done pulse at t+2.
// - Timeout: wait counter (clog2(ZEITLIMIT+1) bits) clears on entry; if it reaches ZEITLIMIT without
//   MemBereit: DatenRein <= 0, go to ANTWORT with error flag. MemBereit in the limit cycle wins.
// - ANTWORT: strobes 0; Geladen[k] or Gespeichert[k] = 1 for exactly one cycle, Fehler[k] too if
//   timed out; DatenRein holds value until next read completes. Next state LEERLAUF.
// - Channel served last is masked out of arbitration for the first LEERLAUF cycle after ANTWORT
//   (requester drops its level one cycle after the pulse); no double service.
// - Request withdrawn during ZUGRIFF: access still completes, pulse still issued (ignored).
// - MemBereit outside ZUGRIFF is ignored. Only one memory access outstanding at any time.
// - Min throughput: one access per 3 cycles; RR guarantees service within KANAELE grants.
// TESTING
// 1 Reset mid-ZUGRIFF (MemLesen=1): Reset pulse -> all outputs 0 immediately, no Geladen afterwards.
// 2 K=2 RR: Lesen=2'b11, Adresse0=0x10, Adresse1=0x20, MemBereit 1 cycle after strobe
//   -> MemAdresse order 0x10,0x20,0x10,0x20; Geladen alternates 01,10.
// 3 FESTE_PRIO=1, both channels requesting continuously -> only channel 0 served; channel 1 served
//   only after Lesen[0] drops.
// 4 Write ch1 Adresse=0x40 DatenRaus=0xDEADBEEF -> MemSchreiben=1, MemAdresse=0x40,
//   MemSchreibDaten=0xDEADBEEF; Gespeichert=2'b10 one cycle after MemBereit.
// 5 ZEITLIMIT=4, MemBereit never -> after 4 strobe cycles Geladen[0]=1, Fehler[0]=1, DatenRein=0.
// 6 Lesen[0] and Schreiben[0] both high -> write performed, Gespeichert[0] pulses, Geladen stays 0.

Source files
------------

// File: rtl/speicher_arbiter.sv
// Memory arbiter: KANAELE CPU-style requesters (level request, one-cycle done pulse) share one
// memory port, with round-robin or fixed priority and a response timeout.
module speicher_arbiter #(
  parameter int KANAELE      = 2,
  parameter int ADRESSBREITE = 32,
  parameter int DATENBREITE  = 32,
  parameter int FESTE_PRIO   = 0,
  parameter int ZEITLIMIT    = 255
) (
  input  logic                              Clock,
  input  logic                              Reset,
  input  logic [KANAELE-1:0]                Lesen,
  input  logic [KANAELE-1:0]                Schreiben,
  input  logic [KANAELE*ADRESSBREITE-1:0]   Adresse,
  input  logic [KANAELE*DATENBREITE-1:0]    DatenRaus,
  output logic [DATENBREITE-1:0]            DatenRein,
  output logic [KANAELE-1:0]                Geladen,
  output logic [KANAELE-1:0]                Gespeichert,
  output logic [KANAELE-1:0]                Fehler,
  output logic [ADRESSBREITE-1:0]           MemAdresse,
  output logic [DATENBREITE-1:0]            MemSchreibDaten,
  output logic                              MemLesen,
  output logic                              MemSchreiben,
  input  logic [DATENBREITE-1:0]            MemLeseDaten,
  input  logic                              MemBereit,
  output logic [1:0]                        zustand_dbg
);

  localparam int IW = (KANAELE > 1) ? $clog2(KANAELE) : 1;
  localparam int CW = (ZEITLIMIT > 0) ? $clog2(ZEITLIMIT + 1) : 1;
  localparam logic [CW-1:0] ZL_LETZT = (ZEITLIMIT > 0) ? CW'(ZEITLIMIT - 1) : '0;

  typedef enum logic [1:0] {
    LEERLAUF = 2'd0,
    ZUGRIFF  = 2'd1,
    ANTWORT  = 2'd2
  } zustand_t;

  // Handshake: a channel holds Lesen/Schreiben high until it sees its one-cycle Geladen or
  // Gespeichert pulse; the memory side holds MemLesen/MemSchreiben until a one-cycle MemBereit.
  zustand_t                 zustand_q, zustand_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic [IW-1:0]            ptr_q, ptr_d;
  logic                     schreib_q, schreib_d;
  logic                     maske_q, maske_d;
  logic [ADRESSBREITE-1:0]  adr_q, adr_d;
  logic [DATENBREITE-1:0]   wdat_q, wdat_d;
  logic [DATENBREITE-1:0]   rdat_q, rdat_d;
  logic                     mem_lesen_q, mem_lesen_d;
  logic                     mem_schreiben_q, mem_schreiben_d;
  logic [KANAELE-1:0]       geladen_q, geladen_d;
  logic [KANAELE-1:0]       gespeichert_q, gespeichert_d;
  logic [KANAELE-1:0]       fehler_q, fehler_d;
  logic [CW-1:0]            zeit_q, zeit_d;

  logic [KANAELE-1:0]       roh;
  logic [KANAELE-1:0]       anf;
  logic                     gef;
  logic [IW-1:0]            sieger;
  logic [IW-1:0]            naechst;
  logic                     fertig;
  logic                     abgelaufen;

  // In fixed priority a still-requesting just-served channel blocks lower-priority channels for
  // its masked cycle instead of letting them overtake it.
  always_comb begin
    roh    = Lesen | Schreiben;
    anf    = '0;
    gef    = 1'b0;
    sieger = '0;
    for (int k = 0; k < KANAELE; k++)
      anf[k] = roh[k] && !(maske_q && (idx_q == IW'(k)));
    if (FESTE_PRIO != 0) begin
      for (int k = KANAELE - 1; k >= 0; k--) begin
        if (roh[k]) begin
          gef    = 1'b1;
          sieger = IW'(k);
        end
      end
      if (gef && maske_q && (sieger == idx_q)) gef = 1'b0;
    end else begin
      for (int i = KANAELE - 1; i >= 0; i--) begin
        if (anf[(int'(ptr_q) + i) % KANAELE]) begin
          gef    = 1'b1;
          sieger = IW'((int'(ptr_q) + i) % KANAELE);
        end
      end
    end
    naechst = (sieger == IW'(KANAELE - 1)) ? '0 : sieger + IW'(1);
  end

  always_comb begin
    zustand_d       = zustand_q;
    idx_d           = idx_q;
    ptr_d           = ptr_q;
    schreib_d       = schreib_q;
    maske_d         = 1'b0;
    adr_d           = adr_q;
    wdat_d          = wdat_q;
    rdat_d          = rdat_q;
    mem_lesen_d     = mem_lesen_q;
    mem_schreiben_d = mem_schreiben_q;
    geladen_d       = '0;
    gespeichert_d   = '0;
    fehler_d        = '0;
    zeit_d          = zeit_q;
    fertig          = 1'b0;
    abgelaufen      = 1'b0;
    case (zustand_q)
      LEERLAUF: begin
        if (gef) begin
          idx_d           = sieger;
          schreib_d       = Schreiben[sieger];
          adr_d           = Adresse[int'(sieger)*ADRESSBREITE +: ADRESSBREITE];
          wdat_d          = DatenRaus[int'(sieger)*DATENBREITE +: DATENBREITE];
          mem_lesen_d     = !Schreiben[sieger];
          mem_schreiben_d = Schreiben[sieger];
          zeit_d          = '0;
          if (FESTE_PRIO == 0) ptr_d = naechst;
          zustand_d       = ZUGRIFF;
        end
      end
      ZUGRIFF: begin
        if (MemBereit) begin
          fertig = 1'b1;
          if (!schreib_q) rdat_d = MemLeseDaten;
        end else if ((ZEITLIMIT != 0) && (zeit_q == ZL_LETZT)) begin
          fertig     = 1'b1;
          abgelaufen = 1'b1;
          rdat_d     = '0;
        end else begin
          zeit_d = zeit_q + CW'(1);
        end
        if (fertig) begin
          mem_lesen_d            = 1'b0;
          mem_schreiben_d        = 1'b0;
          geladen_d[idx_q]       = !schreib_q;
          gespeichert_d[idx_q]   = schreib_q;
          fehler_d[idx_q]        = abgelaufen;
          zustand_d              = ANTWORT;
        end
      end
      ANTWORT: begin
        maske_d   = 1'b1;
        zustand_d = LEERLAUF;
      end
      default: zustand_d = LEERLAUF;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      zustand_q       <= LEERLAUF;
      idx_q           <= '0;
      ptr_q           <= '0;
      schreib_q       <= 1'b0;
      maske_q         <= 1'b0;
      adr_q           <= '0;
      wdat_q          <= '0;
      rdat_q          <= '0;
      mem_lesen_q     <= 1'b0;
      mem_schreiben_q <= 1'b0;
      geladen_q       <= '0;
      gespeichert_q   <= '0;
      fehler_q        <= '0;
      zeit_q          <= '0;
    end else begin
      zustand_q       <= zustand_d;
      idx_q           <= idx_d;
      ptr_q           <= ptr_d;
      schreib_q       <= schreib_d;
      maske_q         <= maske_d;
      adr_q           <= adr_d;
      wdat_q          <= wdat_d;
      rdat_q          <= rdat_d;
      mem_lesen_q     <= mem_lesen_d;
      mem_schreiben_q <= mem_schreiben_d;
      geladen_q       <= geladen_d;
      gespeichert_q   <= gespeichert_d;
      fehler_q        <= fehler_d;
      zeit_q          <= zeit_d;
    end
  end

  assign DatenRein       = rdat_q;
  assign Geladen         = geladen_q;
  assign Gespeichert     = gespeichert_q;
  assign Fehler          = fehler_q;
  assign MemAdresse      = adr_q;
  assign MemSchreibDaten = wdat_q;
  assign MemLesen        = mem_lesen_q;
  assign MemSchreiben    = mem_schreiben_q;
  assign zustand_dbg     = zustand_q;

endmodule

// File: tb/tb_speicher_arbiter.sv
// Bench for speicher_arbiter: a round-robin and a fixed-priority instance, directed scenarios
// plus randomized requesters checked against a transaction-level memory/arbitration model.
module tb_speicher_arbiter;
  localparam int K  = 2;
  localparam int AB = 32;
  localparam int DB = 32;
  localparam int EW = 1 + AB + DB;

  logic Clock = 1'b0;
  logic Reset = 1'b1;
  always #5 Clock = ~Clock;

  logic [K-1:0] r_lesen = '0, r_schreiben = '0, f_lesen = '0, f_schreiben = '0;
  logic [K*AB-1:0] r_adresse = '0, f_adresse = '0;
  logic [K*DB-1:0] r_datenraus = '0, f_datenraus = '0;
  logic [DB-1:0] r_datenrein, f_datenrein, r_mem_wd, f_mem_wd;
  logic [DB-1:0] r_mem_rd = '0, f_mem_rd = '0;
  logic [K-1:0] r_geladen, r_gespeichert, r_fehler, f_geladen, f_gespeichert, f_fehler;
  logic [AB-1:0] r_mem_adr, f_mem_adr;
  logic r_mem_les, r_mem_schr, f_mem_les, f_mem_schr;
  logic r_mem_bereit = 1'b0, f_mem_bereit = 1'b0;
  logic [1:0] r_dbg, f_dbg;

  speicher_arbiter #(.KANAELE(K), .ADRESSBREITE(AB), .DATENBREITE(DB), .FESTE_PRIO(0), .ZEITLIMIT(4)) u_rr (
    .Clock(Clock), .Reset(Reset), .Lesen(r_lesen), .Schreiben(r_schreiben), .Adresse(r_adresse),
    .DatenRaus(r_datenraus), .DatenRein(r_datenrein), .Geladen(r_geladen), .Gespeichert(r_gespeichert),
    .Fehler(r_fehler), .MemAdresse(r_mem_adr), .MemSchreibDaten(r_mem_wd), .MemLesen(r_mem_les),
    .MemSchreiben(r_mem_schr), .MemLeseDaten(r_mem_rd), .MemBereit(r_mem_bereit), .zustand_dbg(r_dbg));

  speicher_arbiter #(.KANAELE(K), .ADRESSBREITE(AB), .DATENBREITE(DB), .FESTE_PRIO(1), .ZEITLIMIT(4)) u_fp (
    .Clock(Clock), .Reset(Reset), .Lesen(f_lesen), .Schreiben(f_schreiben), .Adresse(f_adresse),
    .DatenRaus(f_datenraus), .DatenRein(f_datenrein), .Geladen(f_geladen), .Gespeichert(f_gespeichert),
    .Fehler(f_fehler), .MemAdresse(f_mem_adr), .MemSchreibDaten(f_mem_wd), .MemLesen(f_mem_les),
    .MemSchreiben(f_mem_schr), .MemLeseDaten(f_mem_rd), .MemBereit(f_mem_bereit), .zustand_dbg(f_dbg));

  logic [EW-1:0] exp_q[$];
  logic [DB-1:0] mem [logic [AB-1:0]];
  int n_checks = 0;
  int n_fail = 0;
  int resp_mode = 0;
  int resp_delay = 0;
  int cur_delay = 0;
  int wait_cnt = 0;
  logic junk_en = 1'b0;

  function automatic logic [DB-1:0] mem_read(input logic [AB-1:0] a);
    if (mem.exists(a)) return mem[a];
    return ~a;
  endfunction

  // One clock: wait for the falling edge, then act as the memory for both instances.
  task automatic tick();
    logic [DB-1:0] rd;
    @(negedge Clock);
    if (r_mem_les || r_mem_schr) begin
      if (resp_mode != 0 && wait_cnt >= cur_delay) begin
        r_mem_bereit = 1'b1;
        if (r_mem_schr) begin
          mem[r_mem_adr] = r_mem_wd;
          exp_q.push_back({1'b1, r_mem_adr, r_mem_wd});
        end else begin
          rd = mem_read(r_mem_adr);
          r_mem_rd = rd;
          exp_q.push_back({1'b0, r_mem_adr, rd});
        end
      end else begin
        r_mem_bereit = 1'b0;
        wait_cnt++;
      end
    end else begin
      r_mem_bereit = junk_en ? 1'($urandom_range(0, 1)) : 1'b0;
      r_mem_rd = $urandom();
      wait_cnt = 0;
      cur_delay = (resp_mode == 2) ? int'($urandom_range(0, 2)) : resp_delay;
    end
    f_mem_bereit = f_mem_les | f_mem_schr;
    f_mem_rd = ~f_mem_adr;
  endtask

  task automatic do_reset(input int mode, input int dly);
    Reset = 1'b1;
    r_lesen = '0; r_schreiben = '0; f_lesen = '0; f_schreiben = '0;
    resp_mode = mode; resp_delay = dly; junk_en = 1'b0;
    tick();
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    logic seen;
    tick();
    n_checks++;
    if ({r_geladen, r_gespeichert, r_fehler, r_mem_les, r_mem_schr, r_dbg} !== '0) begin
      n_fail++; $display("FAIL reset_rr_ctrl: got %h expected 0", {r_geladen, r_gespeichert, r_fehler, r_mem_les, r_mem_schr, r_dbg});
    end
    n_checks++;
    if ({r_datenrein, r_mem_adr, r_mem_wd} !== '0) begin
      n_fail++; $display("FAIL reset_rr_data: got %h expected 0", {r_datenrein, r_mem_adr, r_mem_wd});
    end
    n_checks++;
    if ({f_geladen, f_gespeichert, f_fehler, f_mem_les, f_mem_schr, f_dbg, f_datenrein} !== '0) begin
      n_fail++; $display("FAIL reset_fp: got %h expected 0", {f_geladen, f_gespeichert, f_fehler, f_mem_les, f_mem_schr, f_dbg, f_datenrein});
    end
    Reset = 1'b0;
    resp_mode = 0;
    r_adresse[0 +: AB] = 32'h10;
    r_lesen = 2'b01;
    tick();
    tick();
    n_checks++;
    if (r_mem_les !== 1'b1 || r_mem_adr !== 32'h10) begin
      n_fail++; $display("FAIL reset_pre_strobe: got les=%b adr=%h expected les=1 adr=10", r_mem_les, r_mem_adr);
    end
    #2 Reset = 1'b1;
    #1;
    n_checks++;
    if ({r_mem_les, r_mem_schr, r_mem_adr, r_dbg, r_geladen} !== '0) begin
      n_fail++; $display("FAIL reset_async: got %h expected 0", {r_mem_les, r_mem_schr, r_mem_adr, r_dbg, r_geladen});
    end
    r_lesen = '0;
    tick();
    Reset = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      tick();
      if (r_geladen != '0 || r_fehler != '0 || r_mem_les) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL reset_no_pulse: got activity=%b expected 0", seen);
    end
  endtask

  task automatic test_rr_alternate();
    logic [AB-1:0] adrs[$];
    logic [K-1:0] pulses[$];
    logic [AB-1:0] exp_adr[4];
    logic [K-1:0] exp_p[4];
    logic prev;
    logic [AB-1:0] a;
    exp_adr = '{32'h10, 32'h20, 32'h10, 32'h20};
    exp_p = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset(1, 1);
    r_adresse = {32'h20, 32'h10};
    r_lesen = 2'b11;
    prev = 1'b0;
    for (int c = 0; c < 40 && (adrs.size() < 4 || pulses.size() < 4); c++) begin
      tick();
      if (r_mem_les && !prev) adrs.push_back(r_mem_adr);
      prev = r_mem_les;
      if (r_geladen != '0) begin
        pulses.push_back(r_geladen);
        a = (r_geladen == 2'b01) ? 32'h10 : 32'h20;
        n_checks++;
        if (r_datenrein !== mem_read(a)) begin
          n_fail++; $display("FAIL rr_rdata: got %h expected %h", r_datenrein, mem_read(a));
        end
      end
    end
    r_lesen = '0;
    n_checks++;
    if (adrs.size() < 4 || pulses.size() < 4) begin
      n_fail++; $display("FAIL rr_count: got %0d/%0d expected 4/4", adrs.size(), pulses.size());
    end
    for (int i = 0; i < 4; i++) begin
      if (i < adrs.size() && i < pulses.size()) begin
        n_checks++;
        if (adrs[i] !== exp_adr[i] || pulses[i] !== exp_p[i]) begin
          n_fail++; $display("FAIL rr_order[%0d]: got adr=%h pulse=%b expected adr=%h pulse=%b", i, adrs[i], pulses[i], exp_adr[i], exp_p[i]);
        end
      end
    end
    repeat (4) tick();
  endtask

  task automatic test_fixed_prio();
    int n0;
    int bad;
    logic got;
    do_reset(1, 0);
    f_adresse = {32'h20, 32'h10};
    f_lesen = 2'b11;
    n0 = 0; bad = 0;
    repeat (20) begin
      tick();
      if (f_geladen == 2'b01) n0++;
      else if (f_geladen != '0) bad++;
    end
    n_checks++;
    if (n0 < 4 || bad != 0) begin
      n_fail++; $display("FAIL fixed_only_ch0: got ch0=%0d other=%0d expected ch0>=4 other=0", n0, bad);
    end
    f_lesen = 2'b10;
    got = 1'b0;
    for (int c = 0; c < 12 && !got; c++) begin
      tick();
      if (f_geladen == 2'b10) got = 1'b1;
    end
    f_lesen = '0;
    n_checks++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL fixed_ch1_after_drop: got served=%b expected 1", got);
    end
    repeat (4) tick();
  endtask

  task automatic test_write();
    do_reset(1, 0);
    r_adresse[AB +: AB] = 32'h40;
    r_datenraus[DB +: DB] = 32'hDEADBEEF;
    r_schreiben = 2'b10;
    tick();
    n_checks++;
    if (r_mem_schr !== 1'b1 || r_mem_les !== 1'b0 || r_mem_adr !== 32'h40 || r_mem_wd !== 32'hDEADBEEF) begin
      n_fail++; $display("FAIL write_bus: got schr=%b les=%b adr=%h wd=%h expected 1 0 40 deadbeef", r_mem_schr, r_mem_les, r_mem_adr, r_mem_wd);
    end
    tick();
    n_checks++;
    if (r_gespeichert !== 2'b10 || r_geladen !== 2'b00 || r_fehler !== 2'b00) begin
      n_fail++; $display("FAIL write_done: got gesp=%b gel=%b feh=%b expected 10 00 00", r_gespeichert, r_geladen, r_fehler);
    end
    r_schreiben = '0;
    tick();
    n_checks++;
    if (r_gespeichert !== 2'b00 || r_mem_schr !== 1'b0) begin
      n_fail++; $display("FAIL write_pulse_len: got gesp=%b schr=%b expected 00 0", r_gespeichert, r_mem_schr);
    end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    int n_str;
    logic got;
    logic [K-1:0] gel, feh;
    logic [DB-1:0] dat;
    do_reset(1, 0);
    r_adresse[0 +: AB] = 32'h10;
    r_lesen = 2'b01;
    tick();
    tick();
    n_checks++;
    if (r_geladen !== 2'b01 || r_datenrein !== mem_read(32'h10)) begin
      n_fail++; $display("FAIL timeout_preload: got gel=%b dat=%h expected 01 %h", r_geladen, r_datenrein, mem_read(32'h10));
    end
    r_lesen = '0;
    resp_mode = 0;
    tick();
    r_adresse[0 +: AB] = 32'h80;
    r_lesen = 2'b01;
    n_str = 0; got = 1'b0; gel = '0; feh = '0; dat = '1;
    for (int c = 0; c < 20 && !got; c++) begin
      tick();
      if (r_mem_les) n_str++;
      if (r_geladen != '0) begin
        got = 1'b1; gel = r_geladen; feh = r_fehler; dat = r_datenrein;
      end
    end
    r_lesen = '0;
    n_checks++;
    if (got !== 1'b1 || n_str != 4) begin
      n_fail++; $display("FAIL timeout_cycles: got done=%b strobes=%0d expected 1 4", got, n_str);
    end
    n_checks++;
    if (gel !== 2'b01 || feh !== 2'b01 || dat !== '0) begin
      n_fail++; $display("FAIL timeout_resp: got gel=%b feh=%b dat=%h expected 01 01 0", gel, feh, dat);
    end
    tick();
    n_checks++;
    if (r_fehler !== 2'b00) begin
      n_fail++; $display("FAIL timeout_pulse_len: got feh=%b expected 00", r_fehler);
    end
    resp_mode = 1;
    repeat (3) tick();
  endtask

  task automatic test_both();
    do_reset(1, 0);
    r_adresse[0 +: AB] = 32'h44;
    r_datenraus[0 +: DB] = 32'hCAFEF00D;
    r_lesen = 2'b01;
    r_schreiben = 2'b01;
    tick();
    n_checks++;
    if (r_mem_schr !== 1'b1 || r_mem_les !== 1'b0 || r_mem_wd !== 32'hCAFEF00D) begin
      n_fail++; $display("FAIL both_bus: got schr=%b les=%b wd=%h expected 1 0 cafef00d", r_mem_schr, r_mem_les, r_mem_wd);
    end
    tick();
    n_checks++;
    if (r_gespeichert !== 2'b01 || r_geladen !== 2'b00) begin
      n_fail++; $display("FAIL both_done: got gesp=%b gel=%b expected 01 00", r_gespeichert, r_geladen);
    end
    r_lesen = '0;
    r_schreiben = '0;
    repeat (3) tick();
  endtask

  task automatic test_random();
    logic act[K], kind[K], both[K], pulsed[K];
    logic [AB-1:0] adr[K];
    logic [DB-1:0] wd[K];
    int gap[K], waits[K];
    logic [K-1:0] p;
    logic [EW-1:0] e;
    logic stop, busy;
    do_reset(2, 0);
    junk_en = 1'b1;
    exp_q.delete();
    for (int k = 0; k < K; k++) begin
      act[k] = 1'b0; kind[k] = 1'b0; both[k] = 1'b0; adr[k] = '0; wd[k] = '0; gap[k] = k; waits[k] = 0;
    end
    stop = 1'b0;
    for (int c = 0; c < 3200; c++) begin
      if (c >= 3000) stop = 1'b1;
      tick();
      p = r_geladen | r_gespeichert;
      if (p != '0) begin
        n_checks++;
        if ((p & (p - 2'd1)) != '0 || r_fehler != '0) begin
          n_fail++; $display("FAIL rand_pulse: got pulses=%b err=%b expected one-hot no err", p, r_fehler);
        end
      end
      for (int k = 0; k < K; k++) begin
        pulsed[k] = p[k];
        if (p[k]) begin
          n_checks++;
          if (!act[k]) begin
            n_fail++; $display("FAIL rand_spurious: got pulse on ch%0d expected none", k);
          end else if (exp_q.size() == 0) begin
            n_fail++; $display("FAIL rand_scoreboard: got pulse ch%0d expected a completed access", k);
          end else begin
            e = exp_q.pop_front();
            if (r_gespeichert[k] !== kind[k] || e[EW-1] !== kind[k] || e[AB+DB-1:DB] !== adr[k]) begin
              n_fail++; $display("FAIL rand_access ch%0d: got kind=%b/%b adr=%h expected kind=%b adr=%h", k, r_gespeichert[k], e[EW-1], e[AB+DB-1:DB], kind[k], adr[k]);
            end
            n_checks++;
            if (kind[k] ? (e[DB-1:0] !== wd[k]) : (r_datenrein !== e[DB-1:0])) begin
              n_fail++; $display("FAIL rand_data ch%0d: got %h expected %h", k, kind[k] ? e[DB-1:0] : r_datenrein, kind[k] ? wd[k] : e[DB-1:0]);
            end
            n_checks++;
            if (waits[k] > K - 1) begin
              n_fail++; $display("FAIL rand_fairness ch%0d: got %0d other grants expected <= %0d", k, waits[k], K - 1);
            end
          end
          for (int j = 0; j < K; j++) if (j != k && act[j]) waits[j]++;
          act[k] = 1'b0;
          gap[k] = int'($urandom_range(0, 3));
        end
      end
      for (int k = 0; k < K; k++) begin
        if (!act[k] && !pulsed[k] && !stop) begin
          if (gap[k] == 0) begin
            act[k] = 1'b1;
            kind[k] = 1'($urandom_range(0, 1));
            both[k] = 1'($urandom_range(0, 1));
            adr[k] = AB'(4 * $urandom_range(0, 15));
            wd[k] = $urandom();
            waits[k] = 0;
          end else begin
            gap[k]--;
          end
        end
        r_lesen[k] = act[k] && (!kind[k] || both[k]);
        r_schreiben[k] = act[k] && kind[k];
        r_adresse[k*AB +: AB] = adr[k];
        r_datenraus[k*DB +: DB] = wd[k];
      end
    end
    busy = 1'b0;
    for (int k = 0; k < K; k++) if (act[k]) busy = 1'b1;
    n_checks++;
    if (busy || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_drain: got busy=%b pending=%0d expected 0 0", busy, exp_q.size());
    end
    junk_en = 1'b0;
    r_lesen = '0;
    r_schreiben = '0;
  endtask

  initial begin
    test_reset();
    test_rr_alternate();
    test_fixed_prio();
    test_write();
    test_timeout();
    test_both();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
